// File: rtl/display_pkg.sv
// Shared text-display definitions: ASCII control codes, console FSM states and
// standard screen geometries. DISPLAY_CONSOLE_TAB_EN adds the TAB console state.
package display_pkg;

    localparam int COLS_40 = 40;
    localparam int COLS_80 = 80;
    localparam int ROWS_30 = 30;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
`ifdef DISPLAY_CONSOLE_TAB_EN
        ,
        TAB
`endif
    } state_t;

endpackage

// File: rtl/display_console_if.sv
// Byte stream into the console plus the VRAM write port it drives.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
// in_data is only meaningful when in_valid is high, and the source holds it until then.
interface display_console_if #(
    parameter int AW = 12
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          we;

    modport master (
        output in_data, in_valid,
        input  in_ready, waddr, wdata, we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, waddr, wdata, we
    );
endinterface

// File: rtl/display_console.sv
// Character console feeding the text display VRAM: cursor tracking, auto-wrap,
// row clear on entry and full clear on form feed. DISPLAY_CONSOLE_TAB_EN enables tab stops.
module display_console
    import display_pkg::*;
#(
    parameter int COLS           = COLS_40,
    parameter int ROWS           = ROWS_30,
    parameter int AW             = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    display_console_if.slave bus,
    output logic [6:0]       cur_col,
    output logic [4:0]       cur_row,
    output logic             busy,
    output state_t           state
);

    localparam logic [AW:0]   ROW_LEN    = (AW+1)'(COLS);
    localparam logic [AW:0]   SCREEN_LEN = (AW+1)'(COLS * ROWS);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(COLS);
    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
    localparam logic [6:0]    COL_LAST   = 7'(COLS - 1);
    localparam logic [4:0]    ROW_LAST   = 5'(ROWS - 1);
    localparam state_t        RST_STATE  = CLEAR_ON_RESET ? CLEAR_ALL : IDLE;

    logic [AW-1:0] rowbase;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] nl_rowbase;
    logic [4:0]    nl_row;
    logic [6:0]    col_inc;
    logic [AW:0]   cnt;
    logic          printable;
`ifdef DISPLAY_CONSOLE_TAB_EN
    logic          tab_stop;
`endif

    // rowbase tracks cur_row*COLS by stepping, so no multiplier is needed.
    always_comb begin
        cur_addr  = rowbase + AW'(cur_col);
        col_inc   = cur_col + 7'd1;
        printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
        if (cur_row == ROW_LAST) begin
            nl_row     = '0;
            nl_rowbase = '0;
        end else begin
            nl_row     = cur_row + 5'd1;
            nl_rowbase = rowbase + ROW_STEP;
        end
`ifdef DISPLAY_CONSOLE_TAB_EN
        tab_stop = (col_inc[2:0] == 3'd0);
`endif
    end

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            cnt       <= '0;
            rowbase   <= '0;
            cur_col   <= '0;
            cur_row   <= '0;
            bus.we    <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
        end else begin
            bus.we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (printable) begin
                            bus.we    <= 1'b1;
                            bus.waddr <= cur_addr;
                            bus.wdata <= bus.in_data;
                            // Wrap: the row clear starts right after the char write.
                            if (cur_col == COL_LAST) begin
                                cur_col <= '0;
                                cur_row <= nl_row;
                                rowbase <= nl_rowbase;
                                cnt     <= '0;
                                state   <= CLEAR_ROW;
                            end else begin
                                cur_col <= col_inc;
                            end
                        end else begin
                            case (bus.in_data)
                                CH_LF: begin
                                    bus.we    <= 1'b1;
                                    bus.waddr <= nl_rowbase;
                                    bus.wdata <= CH_SPACE;
                                    cur_col   <= '0;
                                    cur_row   <= nl_row;
                                    rowbase   <= nl_rowbase;
                                    cnt       <= CNT_ONE;
                                    state     <= CLEAR_ROW;
                                end
                                CH_CR: cur_col <= '0;
                                CH_BS: begin
                                    if (cur_col != '0) begin
                                        cur_col   <= cur_col - 7'd1;
                                        bus.we    <= 1'b1;
                                        bus.waddr <= cur_addr - ADDR_ONE;
                                        bus.wdata <= CH_SPACE;
                                    end
                                end
                                CH_FF: begin
                                    bus.we    <= 1'b1;
                                    bus.waddr <= '0;
                                    bus.wdata <= CH_SPACE;
                                    cur_col   <= '0;
                                    cur_row   <= '0;
                                    rowbase   <= '0;
                                    cnt       <= CNT_ONE;
                                    state     <= CLEAR_ALL;
                                end
`ifdef DISPLAY_CONSOLE_TAB_EN
                                CH_TAB: begin
                                    bus.we    <= 1'b1;
                                    bus.waddr <= cur_addr;
                                    bus.wdata <= CH_SPACE;
                                    if (cur_col == COL_LAST) begin
                                        cur_col <= '0;
                                        cur_row <= nl_row;
                                        rowbase <= nl_rowbase;
                                        cnt     <= '0;
                                        state   <= CLEAR_ROW;
                                    end else begin
                                        cur_col <= col_inc;
                                        state   <= tab_stop ? IDLE : TAB;
                                    end
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                CLEAR_ROW: begin
                    if (cnt == ROW_LEN) begin
                        state <= IDLE;
                    end else begin
                        bus.we    <= 1'b1;
                        bus.waddr <= rowbase + cnt[AW-1:0];
                        bus.wdata <= CH_SPACE;
                        cnt       <= cnt + CNT_ONE;
                    end
                end
                CLEAR_ALL: begin
                    if (cnt == SCREEN_LEN) begin
                        state <= IDLE;
                    end else begin
                        bus.we    <= 1'b1;
                        bus.waddr <= cnt[AW-1:0];
                        bus.wdata <= CH_SPACE;
                        cnt       <= cnt + CNT_ONE;
                    end
                end
`ifdef DISPLAY_CONSOLE_TAB_EN
                TAB: begin
                    bus.we    <= 1'b1;
                    bus.waddr <= cur_addr;
                    bus.wdata <= CH_SPACE;
                    if (cur_col == COL_LAST) begin
                        cur_col <= '0;
                        cur_row <= nl_row;
                        rowbase <= nl_rowbase;
                        cnt     <= '0;
                        state   <= CLEAR_ROW;
                    end else begin
                        cur_col <= col_inc;
                        state   <= tab_stop ? IDLE : TAB;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
